rca_pipe_adder: RTL
===================

// Module: rca_pipe_adder
// PURPOSE
//   Parametrised pipelined ripple-carry adder/subtractor built from the team's 1-bit full-adder cells.
//   WIDTH is split into STAGES equal chunks. Chunk k is added in pipeline stage k, and its carry is
//   registered into stage k+1. This gives one result per cycle at a full-clock ripple length of
//   WIDTH/STAGES. It sits between operand sources and the ALU result bus, with valid/ready on both sides.
// PARAMETERS
//   WIDTH   16  operand/sum width in bits; must be a multiple of STAGES
//   STAGES  4   pipeline depth (1..WIDTH); chunk width CW = WIDTH/STAGES
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand beat offered
//   in_ready   out  1      block can accept a beat this cycle
//   a          in   WIDTH  operand A (unsigned/two's complement)
//   b          in   WIDTH  operand B
//   cin        in   1      carry in (add mode only)
//   sub        in   1      1: a - b; 0: a + b + cin
//   out_valid  out  1      result beat present
//   out_ready  in   1      consumer accepts result
//   sum        out  WIDTH  result
//   cout       out  1      carry out of MSB (in sub mode: 1 = no borrow)
//   ovf        out  1      signed overflow (only with RCA_OVF_EN)
// BEHAVIOUR
//   - Reset: all stage valid bits, out_valid, sum, cout and ovf go to 0. in_ready is 1 in the first cycle after reset.
//   - Reset mid-operation flushes every in-flight beat. No partial result is ever presented.
//   - Advance: adv = !out_valid | out_ready. All stages shift together when adv=1 and all hold when adv=0 (global stall).
//   - in_ready = adv. A beat is accepted when in_valid & in_ready.
//   - Bubbles travel as valid=0 stages. Their data is don't-care but must not change sum/cout/ovf while out_valid=0.
//   - Accept stage: b_eff = sub ? ~b : b; c0 = sub ? 1 : cin. cin is ignored in sub mode.
//   - Stage k (0..STAGES-1) adds chunk [k*CW +: CW] of a and b_eff plus the registered carry from stage k-1.
//   - Not-yet-used upper chunks are skew-delayed alongside the beat. Finished lower sum chunks are carried forward.
//   - Latency: exactly STAGES cycles from accept to out_valid=1 with no stall. Each stall cycle adds one.
//   - Throughput: 1 beat/cycle while out_ready=1.
//   - Output holds sum/cout/ovf stable while out_valid & !out_ready.
//   - Simultaneous output pop and input accept in the same cycle is legal and loses no beat.
//   - Ordering is strictly FIFO. sum wraps modulo 2^WIDTH, and cout carries the lost bit.
//   - STAGES=1: fully combinational add with a single register stage, latency 1.
// CONFIGURATION
//   - `RCA_OVF_EN defined: ovf = carry-into-MSB XOR carry-out-of-MSB, registered with the final stage.
//     It follows the same hold/reset rules as sum.
//   - Not defined: the ovf port is still present and tied to 0, and no overflow logic is synthesised.
// STRUCTURE
//   - Package rca_pkg: localparam function chunk_w(WIDTH, STAGES), and a stage-record typedef
//     {valid, carry, a_rem, b_rem, sum_acc}. The package is sized by parameters passed at elaboration.
//   - Sub-module rca_chunk #(CW): combinational CW-bit ripple of FA_1_bit cells (a, b, ci -> s, co, c_msb_in).
//     It is instantiated STAGES times via generate.
//   - Top level holds the stage registers, skew logic and the handshake.
//   - Elaboration check: WIDTH % STAGES != 0 is a fatal error.
// TESTING  (WIDTH=16, STAGES=4 unless noted)
//   - Reset then a=16'h00FF, b=16'h0001, cin=0, sub=0 -> after 4 cycles sum=16'h0100, cout=0, out_valid=1.
//   - a=16'hFFFF, b=16'h0001, cin=1 -> sum=16'h0001, cout=1. Carry ripples across all 4 stage boundaries.
//   - sub=1, a=16'h0005, b=16'h0007 -> sum=16'hFFFE, cout=0. cin=1 is ignored.
//   - Back-to-back 8 beats with out_ready=0 from cycle 6 for 3 cycles: in_ready=0 during the stall,
//     outputs held, then all 8 results in order with no loss or duplication.
//   - rst asserted 2 cycles after 3 accepts -> out_valid never asserts for those beats. The next beat has latency 4.
//   - RCA_OVF_EN: a=16'h7FFF, b=16'h0001 -> ovf=1; sub a=16'h8000, b=16'h0001 -> ovf=1. Without the macro, ovf=0.

Source files
------------

// File: rtl/rca_pkg.sv
// -----------------------------------------------------------------------------
// rca_pkg
//   Shared definitions for the pipelined ripple-carry adder slice.
//   - RCA_DEF_WIDTH / RCA_DEF_STAGES : default geometry used by rca_pipe_adder
//   - chunk_w(width, stages)         : bits handled by one pipeline stage
//   A package cannot take parameters, so the width-dependent stage record
//   {valid, carry, a_rem, b_rem, sum_acc} is declared in rca_pipe_adder from
//   its elaboration parameters.
// -----------------------------------------------------------------------------
package rca_pkg;

    localparam int RCA_DEF_WIDTH  = 16;
    localparam int RCA_DEF_STAGES = 4;

    // Guarded so that an illegal STAGES=0 reaches the elaboration check in the
    // top level instead of faulting on a divide by zero.
    function automatic int chunk_w(input int width, input int stages);
        return (stages > 0) ? (width / stages) : width;
    endfunction

endpackage

// File: rtl/rca_chunk.sv
// -----------------------------------------------------------------------------
// FA_1_bit
//   Single-bit full adder cell.
//   Ports: a, b, ci (in) -> s, co (out)
//
// rca_chunk #(CW)
//   Combinational CW-bit ripple-carry adder built from FA_1_bit cells.
//   Ports:
//     a, b      in  CW  operand chunks
//     ci        in  1   carry into bit 0
//     s         out CW  chunk sum
//     co        out 1   carry out of the chunk MSB
//     c_msb_in  out 1   carry into the chunk MSB (for signed overflow)
// -----------------------------------------------------------------------------
module FA_1_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module rca_chunk
    import rca_pkg::*;
#(
    parameter int CW = 4
) (
    input  logic [CW-1:0] a,
    input  logic [CW-1:0] b,
    input  logic          ci,
    output logic [CW-1:0] s,
    output logic          co,
    output logic          c_msb_in
);
    // c[i] is the carry into bit i; c[CW] leaves the chunk.
    logic [CW:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < CW; i++) begin : g_fa
        FA_1_bit u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co       = c[CW];
    assign c_msb_in = c[CW-1];
endmodule

// File: rtl/rca_pipe_adder.sv
// -----------------------------------------------------------------------------
// rca_pipe_adder #(WIDTH, STAGES)
//   Pipelined ripple-carry adder/subtractor. WIDTH is cut into STAGES chunks of
//   CW bits; stage k adds chunk k using the carry registered by stage k-1, so
//   the longest in-cycle ripple is CW bits. One result per cycle, latency
//   STAGES cycles plus any stall cycles.
//
//   Optional feature macro: RCA_OVF_EN
//     defined     : ovf = carry-into-MSB ^ carry-out-of-MSB, registered with sum
//     not defined : ovf tied to 0, no overflow logic
//
//   Ports:
//     clk        in   1      rising-edge clock
//     rst        in   1      synchronous active-high reset, flushes the pipe
//     in_valid   in   1      operand beat offered
//     in_ready   out  1      beat accepted this cycle when in_valid & in_ready
//     a, b       in   WIDTH  operands
//     cin        in   1      carry in (add mode only)
//     sub        in   1      1: a - b, 0: a + b + cin
//     out_valid  out  1      result beat present
//     out_ready  in   1      consumer takes the result
//     sum        out  WIDTH  result (mod 2^WIDTH)
//     cout       out  1      carry out of MSB (sub mode: 1 = no borrow)
//     ovf        out  1      signed overflow (RCA_OVF_EN only, else 0)
//
//   Handshake: a beat transfers on a side whenever valid & ready are both high
//   at a rising edge. The whole pipe moves as one (adv = !out_valid | out_ready)
//   and in_ready = adv, so a full pipe stalls every stage at once and a pop and
//   an accept in the same cycle both complete. The output stage holds
//   sum/cout/ovf while out_valid & !out_ready, and bubbles never overwrite it.
// -----------------------------------------------------------------------------
module rca_pipe_adder
    import rca_pkg::*;
#(
    parameter int WIDTH  = RCA_DEF_WIDTH,
    parameter int STAGES = RCA_DEF_STAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int CW = chunk_w(WIDTH, STAGES);
    localparam int L  = STAGES - 1;

    if (STAGES < 1 || STAGES > WIDTH) begin : g_bad_stages
        $fatal(1, "rca_pipe_adder: STAGES must be in 1..WIDTH");
    end else if ((WIDTH % STAGES) != 0) begin : g_bad_split
        $fatal(1, "rca_pipe_adder: WIDTH must be a multiple of STAGES");
    end

    // One beat in flight. a_rem/b_rem keep the operands skewed alongside the
    // beat until their chunk is consumed; sum_acc gathers finished chunks.
    typedef struct packed {
        logic             valid;
        logic             carry;
        logic [WIDTH-1:0] a_rem;
        logic [WIDTH-1:0] b_rem;
        logic [WIDTH-1:0] sum_acc;
    } stage_t;

    stage_t acc_in;              // beat as presented at the accept stage
    stage_t cur  [STAGES];       // input record of chunk adder k
    stage_t nxt  [STAGES];       // record after chunk k is folded in
    stage_t pipe [STAGES];       // register after stage k; pipe[L] is the output

    logic [WIDTH-1:0]  cs_all;   // chunk sums, chunk k at [k*CW +: CW]
    logic [STAGES-1:0] co_all;   // chunk carry outs
    logic [STAGES-1:0] cm_all;   // carries into each chunk MSB

    logic adv;

    assign adv      = !pipe[L].valid | out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1; the +1 enters as the stage-0 carry.
    assign acc_in = '{
        valid:   in_valid,
        carry:   sub ? 1'b1 : cin,
        a_rem:   a,
        b_rem:   sub ? ~b : b,
        sum_acc: '0
    };

    always_comb begin
        cur[0] = acc_in;
        for (int k = 1; k < STAGES; k++) begin
            cur[k] = pipe[k-1];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        rca_chunk #(.CW(CW)) u_chunk (
            .a        (cur[k].a_rem[k*CW +: CW]),
            .b        (cur[k].b_rem[k*CW +: CW]),
            .ci       (cur[k].carry),
            .s        (cs_all[k*CW +: CW]),
            .co       (co_all[k]),
            .c_msb_in (cm_all[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            nxt[k]                         = cur[k];
            nxt[k].carry                   = co_all[k];
            nxt[k].sum_acc[k*CW +: CW]     = cs_all[k*CW +: CW];
        end
    end

    // Inner stages only need their valid bit cleared on reset; their data is
    // don't-care while invalid. The output stage is fully cleared and only
    // loads data from a valid beat, so bubbles leave sum/cout untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < L; k++) begin
                pipe[k].valid <= 1'b0;
            end
            pipe[L] <= '0;
        end else if (adv) begin
            for (int k = 0; k < L; k++) begin
                pipe[k] <= nxt[k];
            end
            pipe[L].valid <= nxt[L].valid;
            if (nxt[L].valid) begin
                pipe[L] <= nxt[L];
            end
        end
    end

    assign out_valid = pipe[L].valid;
    assign sum       = pipe[L].sum_acc;
    assign cout      = pipe[L].carry;

`ifdef RCA_OVF_EN
    logic ovf_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
        end else if (adv && nxt[L].valid) begin
            ovf_r <= cm_all[L] ^ co_all[L];
        end
    end

    assign ovf = ovf_r;
`else
    assign ovf = 1'b0;
`endif

endmodule
